// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the decimating FIR.
package fir_pkg;

    // Widest intermediate the helpers accept; fir_decim refuses larger configs.
    localparam int MAX_W = 256;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_WRITE   = 2'd3
    } fir_state_e;

    function automatic logic signed [MAX_W-1:0] dequant(
        input logic signed [MAX_W-1:0] p,
        input int                      qb
    );
        return p >>> qb;
    endfunction

    function automatic logic signed [MAX_W-1:0] saturate(
        input logic signed [MAX_W-1:0] a,
        input int                      w
    );
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        hi = '1;
        hi = hi >> (MAX_W - w + 1);
        lo = ~hi;
        if (a > hi) return hi;
        if (a < lo) return lo;
        return a;
    endfunction

endpackage

// File: rtl/fir_decim_if.sv
// Input-FIFO read side and output-FIFO write side of the decimating FIR.
interface fir_decim_if #(parameter int DATA_WIDTH = 32);
    logic signed [DATA_WIDTH-1:0] x_in;
    logic                         x_empty;
    logic                         x_rd_en;
    logic signed [DATA_WIDTH-1:0] y_out;
    logic                         y_out_full;
    logic                         y_wr_en;

    modport master (output x_in, x_empty, y_out_full, input x_rd_en, y_out, y_wr_en);
    modport slave  (input x_in, x_empty, y_out_full, output x_rd_en, y_out, y_wr_en);
endinterface

// File: rtl/fir_mac.sv
// Two-stage MAC: stage 1 full-width multiply, stage 2 dequantize and accumulate.
module fir_mac
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int COEFF_WIDTH = 32,
    parameter int ACC_W       = 69,
    parameter int QUANT_BITS  = 10
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          valid_in,
    input  logic signed [DATA_WIDTH-1:0]  x,
    input  logic signed [COEFF_WIDTH-1:0] coeff,
    output logic signed [ACC_W-1:0]       acc_out
);
    localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;

    logic signed [PROD_W-1:0] prod_q;
    logic                     prod_vld;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            prod_q   <= '0;
            prod_vld <= 1'b0;
            acc_out  <= '0;
        end else begin
            prod_q   <= PROD_W'(x) * PROD_W'(coeff);
            prod_vld <= valid_in;
            if (prod_vld)
                acc_out <= acc_out + ACC_W'(dequant(MAX_W'(prod_q), QUANT_BITS));
        end
    end
endmodule

// File: rtl/fir_decim.sv
// Decimating FIR: circular sample buffer, one tap per cycle through fir_mac.
// Define FIR_DECIM_SAT_EN to saturate the output instead of wrapping it.
module fir_decim
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int COEFF_WIDTH = 32,
    parameter int TAPS        = 32,
    parameter int DECIMATION  = 8,
    parameter int QUANT_BITS  = 10,
    parameter logic signed [COEFF_WIDTH-1:0] COEFF [TAPS] = '{default: '0}
) (
    input  logic      clock,
    input  logic      reset,
    fir_decim_if.slave bus
);
    localparam int PW    = $clog2(TAPS);
    localparam int ACC_W = DATA_WIDTH + COEFF_WIDTH + PW;

    if (TAPS < 2 || TAPS > 256) begin : g_bad_taps
        $fatal(1, "fir_decim: TAPS must be in 2..256");
    end
    if (DECIMATION < 1 || DECIMATION > TAPS) begin : g_bad_dec
        $fatal(1, "fir_decim: DECIMATION must be in 1..TAPS");
    end
    if (QUANT_BITS < 0 || ACC_W > MAX_W) begin : g_bad_width
        $fatal(1, "fir_decim: QUANT_BITS negative or widths too large");
    end

    fir_state_e                    state;
    logic signed [DATA_WIDTH-1:0]  sbuf [TAPS];
    logic [PW-1:0]                 wr_ptr, rd_ptr, smp_cnt, tap_idx;
    logic                          drain_cnt;
    logic                          pop;
    logic signed [ACC_W-1:0]       acc;
    logic signed [DATA_WIDTH-1:0]  y_final;
    logic signed [COEFF_WIDTH-1:0] coeff_sel;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(TAPS - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        return (p == '0) ? PW'(TAPS - 1) : p - 1'b1;
    endfunction

    assign pop         = (state == ST_LOAD) && !bus.x_empty;
    assign bus.x_rd_en = pop;
    // tap_idx walks COEFF from TAPS-1 down while rd_ptr walks newest to oldest
    assign coeff_sel   = COEFF[tap_idx];

`ifdef FIR_DECIM_SAT_EN
    assign y_final = DATA_WIDTH'(saturate(MAX_W'(acc), DATA_WIDTH));
`else
    assign y_final = DATA_WIDTH'(acc);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_LOAD;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            smp_cnt     <= '0;
            tap_idx     <= '0;
            drain_cnt   <= 1'b0;
            bus.y_out   <= '0;
            bus.y_wr_en <= 1'b0;
            for (int i = 0; i < TAPS; i++) sbuf[i] <= '0;
        end else begin
            bus.y_wr_en <= 1'b0;
            case (state)
                ST_LOAD: if (pop) begin
                    sbuf[wr_ptr] <= bus.x_in;
                    rd_ptr       <= wr_ptr;
                    wr_ptr       <= ptr_inc(wr_ptr);
                    if (smp_cnt == PW'(DECIMATION - 1)) begin
                        smp_cnt <= '0;
                        tap_idx <= PW'(TAPS - 1);
                        state   <= ST_COMPUTE;
                    end else begin
                        smp_cnt <= smp_cnt + 1'b1;
                    end
                end
                ST_COMPUTE: begin
                    rd_ptr  <= ptr_dec(rd_ptr);
                    tap_idx <= tap_idx - 1'b1;
                    if (tap_idx == '0) begin
                        drain_cnt <= 1'b0;
                        state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) state <= ST_WRITE;
                end
                ST_WRITE: if (!bus.y_out_full) begin
                    bus.y_out   <= y_final;
                    bus.y_wr_en <= 1'b1;
                    state       <= ST_LOAD;
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    // Accumulator is cleared while loading so each frame starts from zero
    fir_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .COEFF_WIDTH(COEFF_WIDTH),
        .ACC_W      (ACC_W),
        .QUANT_BITS (QUANT_BITS)
    ) u_mac (
        .clock   (clock),
        .reset   (reset),
        .clear   (state == ST_LOAD),
        .valid_in(state == ST_COMPUTE),
        .x       (sbuf[rd_ptr]),
        .coeff   (coeff_sel),
        .acc_out (acc)
    );
endmodule

// File: tb/tb_fir_decim.sv
// Directed bench for fir_decim: TAPS=4, DECIMATION=2, QUANT_BITS=10.
module tb_fir_decim;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    localparam logic signed [31:0] CA [4] = '{32'sd1024, 32'sd2048, 32'sd3072, 32'sd4096};
    localparam logic signed [31:0] CB [4] = '{32'sd4096, 32'sd4096, 32'sd4096, 32'sd4096};

    fir_decim_if #(.DATA_WIDTH(32)) ifa();
    fir_decim_if #(.DATA_WIDTH(16)) ifb();

    fir_decim #(.DATA_WIDTH(32), .COEFF_WIDTH(32), .TAPS(4), .DECIMATION(2),
                .QUANT_BITS(10), .COEFF(CA)) u_a (.clock(clock), .reset(reset), .bus(ifa));
    fir_decim #(.DATA_WIDTH(16), .COEFF_WIDTH(32), .TAPS(4), .DECIMATION(2),
                .QUANT_BITS(10), .COEFF(CB)) u_b (.clock(clock), .reset(reset), .bus(ifb));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int viol  = 0;
    int qa[$], qb[$], ya[$], yb[$], ya_cyc[$], pa_cyc[$];

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -999999;
    endfunction

    // One cycle: capture outputs, drive FIFO inputs, then account for pops.
    task automatic tick(input bit stall);
        @(negedge clock);
        cyc++;
        if (ifa.y_wr_en) begin ya.push_back(int'(ifa.y_out)); ya_cyc.push_back(cyc); end
        if (ifb.y_wr_en) yb.push_back(int'(ifb.y_out));
        ifa.x_empty = stall || (qa.size() == 0);
        ifa.x_in    = (qa.size() != 0) ? 32'(qa[0]) : '0;
        ifb.x_empty = (qb.size() == 0);
        ifb.x_in    = (qb.size() != 0) ? 16'(qb[0]) : '0;
        #1;
        if (ifa.x_rd_en && ifa.x_empty) viol++;
        if (ifb.x_rd_en && ifb.x_empty) viol++;
        if (!reset && ifa.x_rd_en && !ifa.x_empty) begin
            void'(qa.pop_front());
            pa_cyc.push_back(cyc);
        end
        if (!reset && ifb.x_rd_en && !ifb.x_empty) void'(qb.pop_front());
    endtask

    task automatic do_reset();
        reset = 1'b1;
        qa.delete(); qb.delete();
        repeat (2) tick(1'b0);
        reset = 1'b0;
        ya.delete(); yb.delete(); ya_cyc.delete(); pa_cyc.delete();
    endtask

    task automatic run_a(input int n, input bit rnd);
        for (int i = 0; i < 400 && ya.size() < n; i++) tick(rnd ? 1'($urandom_range(0, 1)) : 1'b0);
    endtask

    task automatic run_b(input int n);
        for (int i = 0; i < 400 && yb.size() < n; i++) tick(1'b0);
    endtask

    initial begin
        reset = 1'b1;
        ifa.x_empty = 1'b1; ifa.x_in = '0; ifa.y_out_full = 1'b0;
        ifb.x_empty = 1'b1; ifb.x_in = '0; ifb.y_out_full = 1'b0;
        repeat (3) tick(1'b0);
        chk("rst_y_out_a", int'(ifa.y_out), 0);
        chk("rst_wr_en_a", int'(ifa.y_wr_en), 0);
        chk("rst_y_out_b", int'(ifb.y_out), 0);
        ifa.x_empty = 1'b0;
        #1;
        chk("rst_load_rd_en", int'(ifa.x_rd_en), 1);
        ifa.x_empty = 1'b1;
        reset = 1'b0;

        // impulse, plus pop-to-push latency
        qa = '{1, 0, 0, 0, 0, 0};
        run_a(3, 1'b0);
        repeat (20) tick(1'b0);
        chk("imp_count", ya.size(), 3);
        chk("imp_y0", qget(ya, 0), 3);
        chk("imp_y1", qget(ya, 1), 1);
        chk("imp_y2", qget(ya, 2), 0);
        chk("imp_latency", qget(ya_cyc, 0) - qget(pa_cyc, 1) - 1, 7);

        do_reset();
        qa = '{1, 1, 1, 1, 1, 1};
        run_a(3, 1'b0);
        chk("pos_y0", qget(ya, 0), 7);
        chk("pos_y1", qget(ya, 1), 10);
        chk("pos_y2", qget(ya, 2), 10);

        do_reset();
        qa = '{-1, -1, -1, -1, -1, -1};
        run_a(3, 1'b0);
        chk("neg_y0", qget(ya, 0), -7);
        chk("neg_y1", qget(ya, 1), -10);
        chk("neg_y2", qget(ya, 2), -10);

        // output FIFO full while the second frame waits in WRITE
        do_reset();
        qa = '{1, 0, 0, 0, 0, 0};
        run_a(1, 1'b0);
        ifa.y_out_full = 1'b1;
        repeat (30) tick(1'b0);
        chk("full_no_wr", ya.size(), 1);
        chk("full_no_pop", qa.size(), 2);
        chk("full_y_hold", int'(ifa.y_out), 3);
        ifa.y_out_full = 1'b0;
        repeat (3) tick(1'b0);
        chk("full_release_cnt", ya.size(), 2);
        chk("full_release_val", qget(ya, 1), 1);
        repeat (3) tick(1'b0);
        chk("full_one_pulse", ya.size(), 2);
        run_a(3, 1'b0);
        chk("full_y2", qget(ya, 2), 0);

        do_reset();
        qa = '{1, 0, 0, 0, 0, 0};
        run_a(3, 1'b1);
        repeat (20) tick(1'b0);
        chk("stall_count", ya.size(), 3);
        chk("stall_y0", qget(ya, 0), 3);
        chk("stall_y1", qget(ya, 1), 1);
        chk("stall_y2", qget(ya, 2), 0);

        // reset in the middle of COMPUTE drops the frame
        do_reset();
        qa = '{1, 0};
        for (int i = 0; i < 20 && pa_cyc.size() < 2; i++) tick(1'b0);
        repeat (2) tick(1'b0);
        reset = 1'b1;
        tick(1'b0);
        reset = 1'b0;
        repeat (20) tick(1'b0);
        chk("abort_no_out", ya.size(), 0);
        qa = '{1, 0, 0, 0, 0, 0};
        run_a(3, 1'b0);
        chk("abort_y0", qget(ya, 0), 3);
        chk("abort_y1", qget(ya, 1), 1);
        chk("abort_y2", qget(ya, 2), 0);

        // 16-bit output: saturate or wrap
        do_reset();
        qb = '{32767, 32767, 32767, 32767, 32767, 32767};
        run_b(3);
`ifdef FIR_DECIM_SAT_EN
        chk("satp_y0", qget(yb, 0), 32767);
        chk("satp_y1", qget(yb, 1), 32767);
        chk("satp_y2", qget(yb, 2), 32767);
`else
        chk("wrapp_y0", qget(yb, 0), -8);
        chk("wrapp_y1", qget(yb, 1), -16);
        chk("wrapp_y2", qget(yb, 2), -16);
`endif
        do_reset();
        qb = '{-32768, -32768, -32768, -32768};
        run_b(2);
`ifdef FIR_DECIM_SAT_EN
        chk("satn_y0", qget(yb, 0), -32768);
        chk("satn_y1", qget(yb, 1), -32768);
`else
        chk("wrapn_y0", qget(yb, 0), 0);
        chk("wrapn_y1", qget(yb, 1), 0);
`endif

        chk("no_empty_pops", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
